// File: rtl/div_seq_if.sv
// Request/response bundle for the sequential divider: operands and start in,
// status flags and results out.
interface div_seq_if #(
  parameter int unsigned N = 24
);
  logic           start;
  logic [2*N-1:0] z;
  logic [N-1:0]   d;
  logic           busy;
  logic           done;
  logic [N-1:0]   q;
  logic [N-1:0]   r;
  logic           sticky;
  logic           dz;
  logic           ovf;

  modport master (
    output start, z, d,
    input  busy, done, q, r, sticky, dz, ovf
  );

  modport slave (
    input  start, z, d,
    output busy, done, q, r, sticky, dz, ovf
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit
// per cycle, with divide-by-zero and quotient-overflow early exits.
module div_seq #(
  parameter int unsigned N = 24
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  d_q, d_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;

  logic          accept;
  logic [N:0]    partial;
  logic          ge;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    accept  = bus.start && (state_q != StRun);
    // quo_q doubles as the shift register for the low dividend bits
    partial = {rem_q, quo_q[N-1]};
    ge      = (partial >= {1'b0, d_q});

    unique case (state_q)
      StRun: begin
        // result is < d, so the low N bits of the modular difference are exact
        rem_d = partial[N-1:0] - (ge ? d_q : '0);
        quo_d = {quo_q[N-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: ;
    endcase

    if (accept) begin
      d_d   = bus.d;
      dz_d  = 1'b0;
      ovf_d = 1'b0;
      cnt_d = '0;
      if (bus.d == '0) begin
        dz_d    = 1'b1;
        quo_d   = '1;
        rem_d   = '0;
        state_d = StDone;
      end else if (bus.z[2*N-1:N] >= bus.d) begin
        ovf_d   = 1'b1;
        quo_d   = '1;
        rem_d   = '0;
        state_d = StDone;
      end else begin
        rem_d   = bus.z[2*N-1:N];
        quo_d   = bus.z[N-1:0];
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      d_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy   = (state_q == StRun);
  assign bus.done   = (state_q == StDone);
  assign bus.q      = quo_q;
  assign bus.r      = rem_q;
  assign bus.sticky = |rem_q;
  assign bus.dz     = dz_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq (N=8): directed, random, ignored-start,
// back-to-back and mid-run reset scenarios against an arithmetic reference.
module tb_div_seq;
  localparam int unsigned N = 8;
  localparam longint unsigned MaxQ = (64'd1 << N) - 1;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  div_seq_if #(.N(N)) bus_if ();

  div_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer division with the flag rules layered on top.
  task automatic model(input longint unsigned z, input longint unsigned d,
                       output logic [N-1:0] eq, output logic [N-1:0] er,
                       output logic edz, output logic eovf,
                       output int elat, output int ebusy);
    edz  = 1'b0;
    eovf = 1'b0;
    if (d == 0) begin
      edz = 1'b1;
      eq  = N'(MaxQ);
      er  = '0;
    end else if (z / d > MaxQ) begin
      eovf = 1'b1;
      eq   = N'(MaxQ);
      er   = '0;
    end else begin
      eq = N'(z / d);
      er = N'(z % d);
    end
    elat  = (edz || eovf) ? 1 : N + 1;
    ebusy = (edz || eovf) ? 0 : N;
  endtask

  // Start one op, scramble operands after acceptance, wait (bounded) for done.
  // lat counts edges including the accepting one.
  task automatic issue(input logic [2*N-1:0] z, input logic [N-1:0] d,
                       output int lat, output int busy_n);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.z     = z;
    bus_if.d     = d;
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.z     = (2*N)'($urandom);
    bus_if.d     = N'($urandom);
    lat    = 1;
    busy_n = 0;
    while (!bus_if.done && lat < 4 * N) begin
      if (bus_if.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.z     = 16'd500;
    bus_if.d     = 8'd10;
    @(negedge clk);
    total++;
    if ({bus_if.busy, bus_if.done, bus_if.dz, bus_if.ovf, bus_if.sticky, bus_if.q, bus_if.r}
        !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b dz=%b ovf=%b sticky=%b q=%0d r=%0d want 0",
               bus_if.busy, bus_if.done, bus_if.dz, bus_if.ovf, bus_if.sticky, bus_if.q, bus_if.r);
    end
    bus_if.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: got busy=%b done=%b want 0 0", bus_if.busy, bus_if.done);
    end
  endtask

  task automatic check_op(input string tag, input logic [2*N-1:0] z, input logic [N-1:0] d,
                          input int lat, input int busy_n);
    logic [N-1:0] eq, er;
    logic         edz, eovf;
    int           elat, ebusy;
    model(z, d, eq, er, edz, eovf, elat, ebusy);
    total++;
    if (lat !== elat) begin
      bad++;
      $display("FAIL %s_latency z=%0d d=%0d: got %0d want %0d", tag, z, d, lat, elat);
    end
    total++;
    if (busy_n !== ebusy) begin
      bad++;
      $display("FAIL %s_busy_cycles z=%0d d=%0d: got %0d want %0d", tag, z, d, busy_n, ebusy);
    end
    total++;
    if (bus_if.q !== eq || bus_if.r !== er) begin
      bad++;
      $display("FAIL %s_qr z=%0d d=%0d: got q=%0d r=%0d want q=%0d r=%0d",
               tag, z, d, bus_if.q, bus_if.r, eq, er);
    end
    total++;
    if (bus_if.sticky !== (er != 0) || bus_if.dz !== edz || bus_if.ovf !== eovf) begin
      bad++;
      $display("FAIL %s_flags z=%0d d=%0d: got sticky=%b dz=%b ovf=%b want %b %b %b",
               tag, z, d, bus_if.sticky, bus_if.dz, bus_if.ovf, (er != 0), edz, eovf);
    end
    // One cycle later: done must have dropped and results must hold.
    @(negedge clk);
    total++;
    if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.q !== eq || bus_if.r !== er ||
        bus_if.dz !== edz || bus_if.ovf !== eovf) begin
      bad++;
      $display("FAIL %s_hold z=%0d d=%0d: got done=%b busy=%b q=%0d r=%0d want 0 0 %0d %0d",
               tag, z, d, bus_if.done, bus_if.busy, bus_if.q, bus_if.r, eq, er);
    end
  endtask

  task automatic test_directed();
    logic [2*N-1:0] zt [5] = '{16'd500, 16'd11, 16'h09FF, 16'd123, 16'h0A00};
    logic [N-1:0]   dt [5] = '{8'd10, 8'd3, 8'h0A, 8'd0, 8'h0A};
    int lat, busy_n;
    for (int i = 0; i < 5; i++) begin
      issue(zt[i], dt[i], lat, busy_n);
      check_op("directed", zt[i], dt[i], lat, busy_n);
    end
  endtask

  task automatic test_random();
    logic [2*N-1:0] z;
    logic [N-1:0]   d;
    int lat, busy_n;
    for (int i = 0; i < 40; i++) begin
      d = N'($urandom);
      if ($urandom_range(0, 7) == 0) d = '0;
      z = (2*N)'($urandom);
      // Bias most ops toward the iterative path
      if (d != 0 && $urandom_range(0, 3) != 0) z = (2*N)'(32'(z) % (32'(d) << N));
      issue(z, d, lat, busy_n);
      check_op("random", z, d, lat, busy_n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int lat, lat2, busy_n;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.z     = 16'd500;
    bus_if.d     = 8'd10;
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (!bus_if.done && lat < 4 * N) begin
      if (bus_if.busy) busy_n++;
      if (lat == 4 || lat >= 6) begin
        bus_if.start = 1'b1;
        bus_if.z     = 16'd11;
        bus_if.d     = 8'd3;
      end else if (lat == 5) begin
        bus_if.start = 1'b0;
        bus_if.z     = '0;
        bus_if.d     = '0;
      end
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== N + 1 || busy_n !== N) begin
      bad++;
      $display("FAIL ignore_start_timing: got lat=%0d busy=%0d want %0d %0d",
               lat, busy_n, N + 1, N);
    end
    total++;
    if (bus_if.q !== 8'd50 || bus_if.r !== 8'd0 || bus_if.dz !== 1'b0 || bus_if.ovf !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start_result: got q=%0d r=%0d dz=%b ovf=%b want 50 0 0 0",
               bus_if.q, bus_if.r, bus_if.dz, bus_if.ovf);
    end
    // start is still high, so this edge accepts the second op from DONE
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    lat2 = 1;
    while (!bus_if.done && lat2 < 4 * N) begin
      @(negedge clk);
      lat2++;
    end
    total++;
    if (lat2 !== N + 1) begin
      bad++;
      $display("FAIL back_to_back_latency: got %0d want %0d", lat2, N + 1);
    end
    total++;
    if (bus_if.q !== 8'd3 || bus_if.r !== 8'd2 || bus_if.sticky !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back_result: got q=%0d r=%0d sticky=%b want 3 2 1",
               bus_if.q, bus_if.r, bus_if.sticky);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int lat, busy_n, seen_done;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.z     = 16'd500;
    bus_if.d     = 8'd10;
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({bus_if.busy, bus_if.done, bus_if.dz, bus_if.ovf, bus_if.sticky, bus_if.q, bus_if.r}
        !== '0) begin
      bad++;
      $display("FAIL midrun_reset_outputs: got busy=%b done=%b q=%0d r=%0d sticky=%b want 0",
               bus_if.busy, bus_if.done, bus_if.q, bus_if.r, bus_if.sticky);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (bus_if.done || bus_if.busy) seen_done++;
    end
    total++;
    if (seen_done !== 0) begin
      bad++;
      $display("FAIL midrun_reset_no_done: got %0d active cycles want 0", seen_done);
    end
    issue(16'd11, 8'd3, lat, busy_n);
    check_op("after_reset", 16'd11, 8'd3, lat, busy_n);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.z     = '0;
    bus_if.d     = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter N, default 24: divisor, quotient and remainder width; dividend width is 2N; N >= 2 SHALL be supported.
REQ-002 clk  input  1  single clock; all state changes SHALL occur on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled on rising clk.
REQ-005 z  input  2N  unsigned dividend; SHALL be sampled only on an accepted start.
REQ-006 d  input  N  unsigned divisor; SHALL be sampled only on an accepted start.
REQ-007 busy  output  1  high while iterating (RUN).
REQ-008 done  output  1  one-cycle pulse; results valid from this cycle.
REQ-009 q  output  N  quotient.
REQ-010 r  output  N  remainder.
REQ-011 sticky  output  1  (r != 0); used for FP rounding.
REQ-012 dz  output  1  divide-by-zero flag.
REQ-013 ovf  output  1  quotient-overflow flag.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, plus an iteration counter of $clog2(N+1) bits.
REQ-015 A start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on the operation or the outputs.
REQ-016 On accept: capture z and d; clear dz and ovf.
REQ-017 On accept with d == 0: go to DONE next cycle; dz=1, q = all ones, r = 0, sticky = 0.
REQ-018 On accept with d != 0 and z[2N-1:N] >= d: go to DONE next cycle; ovf=1, q = all ones, r = 0, sticky = 0.
REQ-019 Otherwise go to RUN with counter = 0.
REQ-020 Each RUN cycle SHALL perform one radix-2 restoring step:
- compare the (N+1)-bit partial remainder with d;
- subtract d if it is greater or equal;
- shift left, inserting the quotient bit at the LSB.
REQ-021 After exactly N RUN cycles, go to DONE.
REQ-022 In DONE: q = floor(z/d) and r = z mod d, each exact in N bits.
REQ-023 Latency: done SHALL assert N+1 rising edges after the accepting edge on the normal path, and 1 edge after it on the dz/ovf paths.
REQ-024 busy SHALL be 1 exactly for the N cycles in RUN and 0 otherwise.
REQ-025 done SHALL be high for exactly the first cycle of DONE.
REQ-026 DONE SHALL fall to IDLE the following cycle unless a start is accepted in it.
REQ-027 q, r, sticky, dz and ovf SHALL hold their DONE values until the next accepted start.
REQ-028 A start in DONE (back-to-back) SHALL be accepted, and done SHALL still pulse for that DONE cycle.
REQ-029 q, r and sticky SHALL not be required to be meaningful while busy = 1.
REQ-030 z and d may change freely after the accepting edge without affecting the result.

Reset
REQ-031 While rst is high, the block SHALL be held in IDLE with counter = 0.
REQ-032 While rst is high: busy = done = dz = ovf = sticky = 0, and q = r = 0.
REQ-033 rst asserted mid-RUN SHALL abort the operation immediately, with no done pulse.
REQ-034 The first start after rst deasserts SHALL be accepted normally.

Verification (N=8)
REQ-035 z=500, d=10, start 1 cycle -> busy 8 cycles; done at edge 9; q=50, r=0, sticky=0, dz=ovf=0.
REQ-036 z=11, d=3 -> q=3, r=2, sticky=1; then z=0x09FF, d=0x0A -> q=0xFF, r=9.
REQ-037 z=123, d=0 -> done 1 edge after accept; dz=1, q=0xFF, r=0, busy never high.
REQ-038 z=0x0A00, d=0x0A -> done 1 edge after accept; ovf=1, q=0xFF, r=0.
REQ-039 Accept z=500, d=10; pulse start with z=11, d=3 at RUN cycle 4 -> ignored, result q=50; then start held high through DONE -> second op (z=11, d=3) accepted back-to-back, done again 9 edges later.
REQ-040 rst pulsed at RUN cycle 3 -> all outputs 0 immediately, no done; a new start then completes with correct results.
